// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffered stage register with a valid/ready
// handshake on both sides. Sustains one word per cycle, and every output
// comes straight from a flop.
//
// Optional feature: define PIPE_FLUSH_EN to add the flush input. Flush drops
// all held words. Without the macro, flush is tied off internally.
//
// state | meaning
// EMPTY | main and skid invalid
// ONE   | main valid, skid invalid
// TWO   | main and skid valid; in_ready low
module pipe_skid_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;
  logic             flush_w;

`ifdef PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and data-load decode. Out_valid and in_ready are decoded from
  // the next state here so that they can be registered.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the consumer side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush invalidates everything. Data contents are left untouched, and a
    // same-cycle in_fire is dropped.
    if (flush_w) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // State, payload and handshake flops with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg. Inputs change and outputs are sampled
// 1 ns after each rising edge. Expected values are written out by hand.
module tb_pipe_skid_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_FLUSH_EN
  logic             flush;
`endif

  int total;
  int passed;

  pipe_skid_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_hs(input string tag, input logic ov, input logic ir);
    check({tag, "_out_valid"}, {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, ov});
    check({tag, "_in_ready"},  {{(WIDTH-1){1'b0}}, in_ready},  {{(WIDTH-1){1'b0}}, ir});
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b0;
`ifdef PIPE_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset held for three cycles while the producer offers a word.
    for (int i = 0; i < 3; i++) begin
      step();
      check_hs("reset", 1'b0, 1'b1);
      check("reset_data", out_data, 8'h00);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check_hs("post_reset", 1'b0, 1'b1);
    check("post_reset_data", out_data, 8'h00);

    // Single word, held under backpressure, then drained.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_hs("single", 1'b1, 1'b1);
    check("single_data", out_data, 8'hA5);
    step();
    step();
    check_hs("single_hold", 1'b1, 1'b1);
    check("single_hold_data", out_data, 8'hA5);
    out_ready = 1'b1;
    step();
    check_hs("single_drain", 1'b0, 1'b1);
    check("single_drain_data_kept", out_data, 8'hA5);

    // Streaming 1..10 with the consumer always ready.
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      step();
      check_hs("stream", 1'b1, 1'b1);
      check("stream_data", out_data, WIDTH'(i));
    end
    in_valid = 1'b0;
    step();
    check_hs("stream_end", 1'b0, 1'b1);

    // Backpressure: 1 and 2 absorbed, 3 held off, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd1;
    step();
    check_hs("bp_one", 1'b1, 1'b1);
    in_data = 8'd2;
    step();
    check_hs("bp_two", 1'b1, 1'b0);
    check("bp_two_data", out_data, 8'd1);
    in_data = 8'd3;
    step();
    check_hs("bp_stall", 1'b1, 1'b0);
    check("bp_stall_data", out_data, 8'd1);
    out_ready = 1'b1;
    step();
    check_hs("bp_drain2", 1'b1, 1'b1);
    check("bp_drain2_data", out_data, 8'd2);
    step();
    in_valid = 1'b0;
    check_hs("bp_drain3", 1'b1, 1'b1);
    check("bp_drain3_data", out_data, 8'd3);
    step();
    check_hs("bp_empty", 1'b0, 1'b1);
    check("bp_empty_data_kept", out_data, 8'd3);

`ifdef PIPE_FLUSH_EN
    // Fill to TWO with 7,8, then flush while 9 is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    step();
    in_data = 8'd8;
    step();
    check_hs("fl_full", 1'b1, 1'b0);
    in_data = 8'd9;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_hs("fl_after", 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    check_hs("fl_no9", 1'b0, 1'b1);
    step();
    check_hs("fl_no9_again", 1'b0, 1'b1);
`endif

    // Reset in TWO, then a fresh word with 1-cycle latency.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    check_hs("mid_full", 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_hs("mid_reset", 1'b0, 1'b1);
    check("mid_reset_data", out_data, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    check_hs("mid_word", 1'b1, 1'b1);
    check("mid_word_data", out_data, 8'h55);
    out_ready = 1'b1;
    step();
    check_hs("mid_drain", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
